// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank: write-port operation encoding.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    INC  = 3'd2,
    DEC  = 3'd3,
    SHL  = 3'd4,
    SHR  = 3'd5,
    ROL  = 3'd6,
    ROR  = 3'd7
  } op_t;

endpackage

// File: rtl/reg_op_unit.sv
// Combinational operate unit: computes the new register value and carry for one op.
module reg_op_unit
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ser_in,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  always_comb begin
    result    = r;
    carry_out = 1'b0;
    case (op)
      HOLD: ;
      LOAD: result = wdata;
      INC: begin
        result    = r + WIDTH'(1);
        carry_out = &r;
      end
      DEC: begin
        result    = r - WIDTH'(1);
        carry_out = ~|r;
      end
      SHL: begin
        result    = {r[WIDTH-2:0], ser_in};
        carry_out = r[WIDTH-1];
      end
      SHR: begin
        result    = {ser_in, r[WIDTH-1:1]};
        carry_out = r[0];
      end
      ROL: begin
        result    = {r[WIDTH-2:0], r[WIDTH-1]};
        carry_out = r[WIDTH-1];
      end
      ROR: begin
        result    = {r[0], r[WIDTH-1:1]};
        carry_out = r[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Working register file: one operate/write port, two combinational read ports,
// registered carry/zero flags and a per-entry dirty map.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 4,
  parameter  bit          BYPASS = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sclr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ser_in,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             carry,
  output logic             zero,
  output logic [DEPTH-1:0] dirty
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] result;
  logic             carry_nx;
  logic             waddr_hit;
  logic             wr_en;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  op_t              op_e;

  assign op_e = op_t'(op);

  // Address decode by loop match keeps out-of-range addresses (non-power-of-2 DEPTH) harmless.
  always_comb begin
    cur       = '0;
    waddr_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i)) begin
        cur       = regs[i];
        waddr_hit = 1'b1;
      end
    end
  end

  assign wr_en = we && (op_e != HOLD) && waddr_hit && !sclr;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .r         (cur),
    .wdata     (wdata),
    .ser_in    (ser_in),
    .op        (op_e),
    .result    (result),
    .carry_out (carry_nx)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      dirty <= '0;
    end else if (sclr) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      dirty <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) begin
          regs[i]  <= result;
          dirty[i] <= 1'b1;
        end
      end
      carry <= carry_nx;
      zero  <= (result == '0);
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) rd_a = regs[i];
      if (raddr_b == AW'(i)) rd_b = regs[i];
    end
    if (BYPASS && wr_en && (raddr_a == waddr)) rd_a = result;
    if (BYPASS && wr_en && (raddr_b == waddr)) rd_b = result;
  end

  // Gating by clear_n keeps the bypass path from leaking a result while in reset.
  assign rdata_a = clear_n ? rd_a : '0;
  assign rdata_b = clear_n ? rd_b : '0;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: write-through, registered and DEPTH=3 variants.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic       clk = 1'b0;
  logic       clear_n, sclr, we, ser_in;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [2:0] op;
  logic [7:0] wdata;

  logic [7:0] a0, b0, a1, b1, a3, b3;
  logic       c0, z0, c1, z1, c3, z3;
  logic [3:0] d0, d1;
  logic [2:0] d3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .we(we), .waddr(waddr), .op(op),
    .wdata(wdata), .ser_in(ser_in), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(a0), .rdata_b(b0), .carry(c0), .zero(z0), .dirty(d0));

  reg_bank #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) dut1 (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .we(we), .waddr(waddr), .op(op),
    .wdata(wdata), .ser_in(ser_in), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(a1), .rdata_b(b1), .carry(c1), .zero(z1), .dirty(d1));

  reg_bank #(.WIDTH(8), .DEPTH(3), .BYPASS(1'b0)) dut3 (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .we(we), .waddr(waddr), .op(op),
    .wdata(wdata), .ser_in(ser_in), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(a3), .rdata_b(b3), .carry(c3), .zero(z3), .dirty(d3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input op_t o, input logic [7:0] d, input logic s);
    waddr = a; op = o; wdata = d; ser_in = s; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; op = HOLD;
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    raddr_a = a; raddr_b = b;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_n = 1'b0; sclr = 1'b0; we = 1'b0; ser_in = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; op = HOLD; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", {24'd0, a0}, 32'h0);
    check("reset_flags", {30'd0, c0, z0}, 32'h0);
    check("reset_dirty", {28'd0, d0}, 32'h0);
    clear_n = 1'b1;

    // 1: async clear without a clock edge
    wr(2'd0, LOAD, 8'h33, 1'b0);
    rd(2'd0, 2'd0);
    check("load_r0", {24'd0, a0}, 32'h33);
    check("load_dirty", {28'd0, d0}, 32'h1);
    #1 clear_n = 1'b0;
    #1;
    check("async_clr_rdata", {24'd0, a0}, 32'h0);
    check("async_clr_dirty", {28'd0, d0}, 32'h0);
    waddr = 2'd0; op = LOAD; wdata = 8'h44; we = 1'b1;
    #1;
    check("reset_bypass_gated", {24'd0, a1}, 32'h0);
    @(posedge clk);
    #1;
    clear_n = 1'b1; we = 1'b0; op = HOLD;
    #1;
    check("inflight_dropped", {24'd0, a0}, 32'h0);
    check("inflight_dirty", {28'd0, d0}, 32'h0);

    // 2: INC wraps
    wr(2'd1, LOAD, 8'hFF, 1'b0);
    wr(2'd1, INC, 8'h00, 1'b0);
    rd(2'd1, 2'd1);
    check("inc_wrap", {24'd0, b0}, 32'h0);
    check("inc_flags", {30'd0, c0, z0}, 32'h3);
    check("inc_dirty", {28'd0, d0}, 32'h2);

    // 3: DEC borrow, then HOLD
    wr(2'd2, DEC, 8'h00, 1'b0);
    rd(2'd2, 2'd2);
    check("dec_borrow", {24'd0, a0}, 32'hFF);
    check("dec_flags", {30'd0, c0, z0}, 32'h2);
    wr(2'd2, HOLD, 8'h12, 1'b0);
    check("hold_val", {24'd0, a0}, 32'hFF);
    check("hold_flags", {30'd0, c0, z0}, 32'h2);
    check("hold_dirty", {28'd0, d0}, 32'h6);

    // 4: shifts and rotates
    wr(2'd0, LOAD, 8'h81, 1'b0);
    wr(2'd0, SHL, 8'h00, 1'b0);
    rd(2'd0, 2'd0);
    check("shl", {23'd0, c0, a0}, {23'd0, 1'b1, 8'h02});
    wr(2'd0, ROR, 8'h00, 1'b0);
    check("ror1", {23'd0, c0, a0}, {23'd0, 1'b0, 8'h01});
    wr(2'd0, ROR, 8'h00, 1'b0);
    check("ror2", {23'd0, c0, a0}, {23'd0, 1'b1, 8'h80});
    wr(2'd0, SHR, 8'h00, 1'b1);
    check("shr_ser1", {23'd0, c0, a0}, {23'd0, 1'b0, 8'hC0});
    wr(2'd0, ROL, 8'h00, 1'b0);
    check("rol", {23'd0, c0, a0}, {23'd0, 1'b1, 8'h81});
    wr(2'd0, DEC, 8'h00, 1'b0);
    check("dec_plain", {22'd0, c0, z0, a0}, {22'd0, 2'b00, 8'h80});

    // 5: write-through vs registered read
    raddr_a = 2'd3; raddr_b = 2'd3;
    waddr = 2'd3; op = LOAD; wdata = 8'h5A; we = 1'b1;
    #1;
    check("bypass_a", {24'd0, a1}, 32'h5A);
    check("bypass_b", {24'd0, b1}, 32'h5A);
    check("nobypass_old", {24'd0, a0}, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0; op = HOLD;
    #1;
    check("nobypass_new", {16'd0, a0, b0}, 32'h5A5A);

    // 6: DEPTH=3 ignores waddr=3 and holds flags; then sclr beats a write
    wr(2'd3, LOAD, 8'h00, 1'b0);
    rd(2'd3, 2'd3);
    check("d3_oor_read", {24'd0, a3}, 32'h0);
    check("d3_flags_hold", {30'd0, c3, z3}, 32'h0);
    check("d3_dirty", {29'd0, d3}, 32'h7);
    check("d4_zero_set", {30'd0, c0, z0}, 32'h1);
    check("d4_dirty_all", {28'd0, d0}, 32'hF);
    sclr = 1'b1;
    wr(2'd0, LOAD, 8'h77, 1'b0);
    sclr = 1'b0;
    rd(2'd0, 2'd2);
    check("sclr_regs", {16'd0, a0, b0}, 32'h0);
    check("sclr_flags", {30'd0, c0, z0}, 32'h0);
    check("sclr_dirty", {28'd0, d0}, 32'h0);
    check("sclr_d3_dirty", {29'd0, d3}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
